// File: rtl/psum_add_tree.sv
// psum_add_tree: pipelined partial-sum reduction for the conv psum path.
// NUM_PE PE psums are reduced through a log2(NUM_PE)-deep pairwise tree.
// Each tree level grows by one bit, so the tree itself never overflows.
// A final stage adds the chained FIFO psum, or zero on a first pass, and
// then saturates or wraps the result back to DATA_WIDTH.
module psum_add_tree #(
  parameter int DATA_WIDTH = 25,
  parameter int NUM_PE     = 4,
  parameter bit SAT_EN     = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic                           in_valid,
  input  logic                           first_pass,
  input  logic [NUM_PE*DATA_WIDTH-1:0]   pe_data,
  input  logic [DATA_WIDTH-1:0]          fifo_data,
  input  logic                           sat_clr,
  output logic [DATA_WIDTH-1:0]          out,
  output logic                           out_valid,
  output logic                           sat_flag
);

  localparam int LEVELS = $clog2(NUM_PE);
  localparam int TW     = DATA_WIDTH + LEVELS;   // tree result width
  localparam int SW     = TW + 1;                // final-sum width

  localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0] SUM_MAX = {{(LEVELS+1){1'b0}}, OUT_MAX};
  localparam logic signed [SW-1:0] SUM_MIN = {{(LEVELS+1){1'b1}}, OUT_MIN};

  logic                  adv_s;
  logic [LEVELS-1:0]     vld_r;
  logic [LEVELS-1:0]     fp_r;
  logic signed [TW-1:0]  tree_s;
  logic signed [SW-1:0]  tree_x_s;
  logic signed [SW-1:0]  fifo_x_s;
  logic signed [SW-1:0]  sum_s;
  logic [DATA_WIDTH-1:0] res_s;
  logic                  clamp_s;

  assign adv_s = ~stall;

  // Stage 0 is the raw PE input; stage k holds NUM_PE>>k values of DATA_WIDTH+k bits.
  for (genvar k = 0; k <= LEVELS; k++) begin : g_stage
    localparam int W = DATA_WIDTH + k;
    localparam int N = NUM_PE >> k;
    logic signed [W-1:0] node [N];

    if (k == 0) begin : g_leaf
      for (genvar j = 0; j < N; j++) begin : g_in
        assign node[j] = pe_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin : g_sum
      for (genvar j = 0; j < N; j++) begin : g_pair
        logic signed [W-1:0] a_s;
        logic signed [W-1:0] b_s;
        assign a_s = {g_stage[k-1].node[2*j][W-2],   g_stage[k-1].node[2*j]};
        assign b_s = {g_stage[k-1].node[2*j+1][W-2], g_stage[k-1].node[2*j+1]};

        // Register the sign-extended pairwise sum of the previous level
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            node[j] <= '0;
          end else if (adv_s) begin
            node[j] <= a_s + b_s;
          end
        end
      end
    end
  end

  assign tree_s = g_stage[LEVELS].node[0];

  // Shift valid and first-pass flags in lockstep with the tree levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= '0;
      fp_r  <= '0;
    end else if (adv_s) begin
      vld_r[0] <= in_valid;
      fp_r[0]  <= first_pass;
      for (int k = 1; k < LEVELS; k++) begin
        vld_r[k] <= vld_r[k-1];
        fp_r[k]  <= fp_r[k-1];
      end
    end
  end

  // Add the chained psum and clamp or wrap back to the output width
  always_comb begin
    tree_x_s = {tree_s[TW-1], tree_s};
    fifo_x_s = '0;
    res_s    = '0;
    clamp_s  = 1'b0;
    if (fp_r[LEVELS-1]) begin
      fifo_x_s = '0;
    end else begin
      fifo_x_s = {{(LEVELS+1){fifo_data[DATA_WIDTH-1]}}, fifo_data};
    end
    sum_s = tree_x_s + fifo_x_s;
    if (SAT_EN) begin
      if (sum_s > SUM_MAX) begin
        res_s   = OUT_MAX;
        clamp_s = 1'b1;
      end else if (sum_s < SUM_MIN) begin
        res_s   = OUT_MIN;
        clamp_s = 1'b1;
      end else begin
        res_s   = sum_s[DATA_WIDTH-1:0];
        clamp_s = 1'b0;
      end
    end else begin
      res_s   = sum_s[DATA_WIDTH-1:0];
      clamp_s = 1'b0;
    end
  end

  // Final stage: register the result and its valid bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (adv_s) begin
      out       <= res_s;
      out_valid <= vld_r[LEVELS-1];
    end
  end

  // Sticky saturation flag; a new clamp event wins over a coincident clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (adv_s && vld_r[LEVELS-1] && clamp_s) begin
      sat_flag <= 1'b1;
    end else if (sat_clr) begin
      sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psum_add_tree.sv
// Self-checking bench for psum_add_tree: four instances (4 PE saturating,
// 4 PE wrapping, 8 PE, 16 PE) with a per-instance expected-result queue.
module tb_psum_add_tree;

  localparam int DW = 25;
  localparam longint MXL = (longint'(1) << (DW-1)) - 1;
  localparam longint MNL = -(longint'(1) << (DW-1));

  typedef struct {
    logic signed [63:0] val;
    int                 due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, stall, sat_clr;
  logic iv_ab, fp_ab, iv_c, fp_c, iv_d, fp_d;
  logic [4*DW-1:0]  pe_ab;
  logic [8*DW-1:0]  pe_c;
  logic [16*DW-1:0] pe_d;
  logic [DW-1:0] fifo_ab, fifo_c, fifo_d;
  logic signed [DW-1:0] out_a, out_b, out_c, out_d;
  logic ov_a, ov_b, ov_c, ov_d, sat_a, sat_b, sat_c, sat_d;

  int ntests = 0;
  int nfail  = 0;
  int adv_cnt = 0;
  exp_t qa[$], qb[$], qc[$], qd[$];
  logic [DW-1:0] fs_ab[int], fs_c[int], fs_d[int];
  logic ev_a, ev_b, ev_c, ev_d;
  logic signed [63:0] eo_a, eo_b, eo_c, eo_d;

  psum_add_tree #(.DATA_WIDTH(DW), .NUM_PE(4), .SAT_EN(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .stall(stall), .in_valid(iv_ab), .first_pass(fp_ab),
    .pe_data(pe_ab), .fifo_data(fifo_ab), .sat_clr(sat_clr),
    .out(out_a), .out_valid(ov_a), .sat_flag(sat_a));
  psum_add_tree #(.DATA_WIDTH(DW), .NUM_PE(4), .SAT_EN(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .stall(stall), .in_valid(iv_ab), .first_pass(fp_ab),
    .pe_data(pe_ab), .fifo_data(fifo_ab), .sat_clr(sat_clr),
    .out(out_b), .out_valid(ov_b), .sat_flag(sat_b));
  psum_add_tree #(.DATA_WIDTH(DW), .NUM_PE(8), .SAT_EN(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .stall(stall), .in_valid(iv_c), .first_pass(fp_c),
    .pe_data(pe_c), .fifo_data(fifo_c), .sat_clr(sat_clr),
    .out(out_c), .out_valid(ov_c), .sat_flag(sat_c));
  psum_add_tree #(.DATA_WIDTH(DW), .NUM_PE(16), .SAT_EN(1'b1)) u_d (
    .clk(clk), .rst_n(rst_n), .stall(stall), .in_valid(iv_d), .first_pass(fp_d),
    .pe_data(pe_d), .fifo_data(fifo_d), .sat_clr(sat_clr),
    .out(out_d), .out_valid(ov_d), .sat_flag(sat_d));

  always #5 clk = ~clk;

  function automatic longint r25();
    logic [DW-1:0] u;
    u = DW'($urandom);
    return longint'($signed(u));
  endfunction

  // Golden model: saturate or wrap a full-precision sum to DW bits.
  function automatic logic signed [63:0] gold(input longint s, input bit sat);
    logic [63:0] t;
    if (sat) begin
      if (s > MXL) return MXL;
      else if (s < MNL) return MNL;
      else return s;
    end
    t = s;
    return {{(64-DW){t[DW-1]}}, t[DW-1:0]};
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
    ntests++;
    assert (obs === exp_v) else begin
      nfail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Pop the scoreboard on advancing edges; hold the expectation while stalled.
  task automatic mon(input string tag, ref exp_t q[$], ref logic ev, ref logic signed [63:0] eo,
                     input logic ov, input logic signed [63:0] o, input bit adv);
    exp_t e;
    if (adv) begin
      ev = 1'b0;
      if (q.size() > 0) begin
        if (q[0].due == adv_cnt) begin
          e  = q.pop_front();
          ev = 1'b1;
          eo = e.val;
        end
      end
    end
    check({tag, "_valid"}, ov, ev);
    if (ev) check({tag, "_out"}, o, eo);
  endtask

  task automatic tick();
    bit adv;
    fifo_ab = fs_ab.exists(adv_cnt+1) ? fs_ab[adv_cnt+1] : DW'($urandom);
    fifo_c  = fs_c.exists(adv_cnt+1)  ? fs_c[adv_cnt+1]  : DW'($urandom);
    fifo_d  = fs_d.exists(adv_cnt+1)  ? fs_d[adv_cnt+1]  : DW'($urandom);
    @(posedge clk);
    adv = (stall == 1'b0);
    if (adv) adv_cnt++;
    #1;
    mon("a", qa, ev_a, eo_a, ov_a, out_a, adv);
    mon("b", qb, ev_b, eo_b, ov_b, out_b, adv);
    mon("c", qc, ev_c, eo_c, ov_c, out_c, adv);
    mon("d", qd, ev_d, eo_d, ov_d, out_d, adv);
    check("b_sat_const", sat_b, 0);
  endtask

  // Present one 4-PE beat for the next (advancing) edge and record its results.
  task automatic drive_ab(input longint p0, input longint p1, input longint p2, input longint p3,
                          input longint f, input bit fp);
    longint s;
    exp_t e;
    pe_ab = {DW'(p3), DW'(p2), DW'(p1), DW'(p0)};
    iv_ab = 1'b1;
    fp_ab = fp;
    s = p0 + p1 + p2 + p3 + (fp ? 64'sd0 : f);
    e.due = adv_cnt + 3;
    fs_ab[e.due] = DW'(f);
    e.val = gold(s, 1'b1); qa.push_back(e);
    e.val = gold(s, 1'b0); qb.push_back(e);
  endtask

  task automatic idle_all();
    iv_ab = 1'b0; fp_ab = 1'b0; iv_c = 1'b0; fp_c = 1'b0; iv_d = 1'b0; fp_d = 1'b0;
    for (int i = 0; i < 4; i++)  pe_ab[i*DW +: DW] = DW'($urandom);
    for (int i = 0; i < 8; i++)  pe_c[i*DW +: DW]  = DW'($urandom);
    for (int i = 0; i < 16; i++) pe_d[i*DW +: DW]  = DW'($urandom);
  endtask

  task automatic rand_beat(input int n, output logic [16*DW-1:0] pe, output logic vb, output logic fp,
                           output logic [DW-1:0] fv, output longint s);
    longint v;
    int r;
    pe = '0;
    s  = 0;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 5);
      if (r == 0) v = MXL;
      else if (r == 1) v = MNL;
      else v = r25();
      pe[i*DW +: DW] = DW'(v);
      s += v;
    end
    v  = r25();
    fv = DW'(v);
    vb = ($urandom_range(0, 3) != 0);
    fp = ($urandom_range(0, 3) == 0);
    if (!fp) s += v;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_a_out"}, out_a, 0); check({tag, "_a_valid"}, ov_a, 0); check({tag, "_a_sat"}, sat_a, 0);
    check({tag, "_b_out"}, out_b, 0); check({tag, "_b_valid"}, ov_b, 0);
    check({tag, "_c_out"}, out_c, 0); check({tag, "_c_valid"}, ov_c, 0); check({tag, "_c_sat"}, sat_c, 0);
    check({tag, "_d_out"}, out_d, 0); check({tag, "_d_valid"}, ov_d, 0); check({tag, "_d_sat"}, sat_d, 0);
  endtask

  initial begin
    logic [16*DW-1:0] pv;
    logic vb, fpb;
    logic [DW-1:0] fv;
    longint s;
    exp_t e;

    rst_n = 1'b1; stall = 1'b0; sat_clr = 1'b0;
    fifo_ab = '0; fifo_c = '0; fifo_d = '0;
    ev_a = 1'b0; ev_b = 1'b0; ev_c = 1'b0; ev_d = 1'b0;
    eo_a = '0; eo_b = '0; eo_c = '0; eo_d = '0;
    idle_all();
    #3 rst_n = 1'b0;
    #1 chk_zero("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();

    // Basic beat: 1+2+3+4+10, output 3 cycles after in_valid.
    drive_ab(1, 2, 3, 4, 10, 1'b0); tick(); idle_all();
    repeat (4) tick();

    // First pass ignores the FIFO operand; back-to-back beat follows.
    drive_ab(5, -7, 100, 2, 999, 1'b1); tick();
    drive_ab(0, 0, 0, 1, -1, 1'b0); tick(); idle_all();
    repeat (4) tick();

    // Positive and negative saturation.
    drive_ab(MXL, MXL, MXL, MXL, MXL, 1'b0); tick(); idle_all(); tick(); tick();
    check("sat_set_pos", sat_a, 1);
    drive_ab(MNL, MNL, MNL, MNL, MNL, 1'b0); tick(); idle_all(); tick(); tick();
    check("sat_sticky", sat_a, 1);
    sat_clr = 1'b1; tick(); sat_clr = 1'b0;
    check("sat_clr", sat_a, 0);

    // Clear coincident with a new saturating result: set wins.
    drive_ab(MXL, MXL, MXL, MXL, MXL, 1'b0); tick(); idle_all(); tick();
    check("sat_not_early", sat_a, 0);
    sat_clr = 1'b1; tick(); sat_clr = 1'b0;
    check("sat_set_wins", sat_a, 1);

    // Clear is honoured while stalled.
    stall = 1'b1; sat_clr = 1'b1; tick(); stall = 1'b0; sat_clr = 1'b0;
    check("sat_clr_stall", sat_a, 0);

    // Stall mid-flight; garbage presented during the stall must be ignored.
    drive_ab(10, 20, 30, 40, 5, 1'b0); tick();
    drive_ab(-1, -2, -3, -4, -100, 1'b0); tick();
    stall = 1'b1; iv_ab = 1'b1; fp_ab = 1'b0; pe_ab = {4{DW'(12345)}};
    repeat (4) tick();
    stall = 1'b0;
    drive_ab(7, 7, 7, 7, 7, 1'b1); tick(); idle_all();
    repeat (5) tick();

    // Async reset between edges with beats in flight.
    drive_ab(MXL, MXL, MXL, MXL, MXL, 1'b0); tick();
    drive_ab(1, 1, 1, 1, 1, 1'b0); tick();
    drive_ab(2, 2, 2, 2, 2, 1'b0); tick();
    check("sat_before_reset", sat_a, 1);
    drive_ab(3, 3, 3, 3, 3, 1'b0); tick(); idle_all();
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    qa.delete(); qb.delete(); qc.delete(); qd.delete();
    fs_ab.delete(); fs_c.delete(); fs_d.delete();
    ev_a = 1'b0; ev_b = 1'b0; ev_c = 1'b0; ev_d = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (6) tick();

    // Random streams on all instances with occasional stalls.
    repeat (300) begin
      stall = ($urandom_range(0, 7) == 0);
      rand_beat(4, pv, vb, fpb, fv, s);
      pe_ab = pv[4*DW-1:0]; iv_ab = vb; fp_ab = fpb;
      if (vb && !stall) begin
        e.due = adv_cnt + 3; fs_ab[e.due] = fv;
        e.val = gold(s, 1'b1); qa.push_back(e);
        e.val = gold(s, 1'b0); qb.push_back(e);
      end
      rand_beat(8, pv, vb, fpb, fv, s);
      pe_c = pv[8*DW-1:0]; iv_c = vb; fp_c = fpb;
      if (vb && !stall) begin
        e.due = adv_cnt + 4; fs_c[e.due] = fv;
        e.val = gold(s, 1'b1); qc.push_back(e);
      end
      rand_beat(16, pv, vb, fpb, fv, s);
      pe_d = pv; iv_d = vb; fp_d = fpb;
      if (vb && !stall) begin
        e.due = adv_cnt + 5; fs_d[e.due] = fv;
        e.val = gold(s, 1'b1); qd.push_back(e);
      end
      tick();
    end
    stall = 1'b0;
    idle_all();
    repeat (8) tick();
    check("drain_a", qa.size(), 0);
    check("drain_b", qb.size(), 0);
    check("drain_c", qc.size(), 0);
    check("drain_d", qd.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
